matrix_scan: RTL and testbench
==============================

// Module: matrix_scan
// PURPOSE
//   Downstream display stage: consumes ball position (x,y) and the two 16-bit paddle masks,
//   composes a 16x16 frame, and scans it row-by-row onto the LED matrix shift registers
//   (column chain CSDI/CCLK/LE, row chain RSDI/RCLK, OEB). Frame inputs are snapshotted once
//   per frame at row 0, so a mid-frame ball/paddle update never tears the displayed image.
// PARAMETERS
//   TIMERWIDTH  10  row dwell = 2**TIMERWIDTH clk cycles with OEB low
//   DIM         16  matrix rows/columns; fixed at 16 (x,y are 4 bits)
// PORTS
//   clk         in   1   system clock
//   reset       in   1   synchronous, active-high
//   x           in   4   ball column, 0..15
//   y           in   4   ball row, 0..15
//   lpaddle     in   16  left paddle mask, bit r = row r lit in column 0
//   rpaddle     in   16  right paddle mask, bit r = row r lit in column 15
//   rclk        out  1   row shift-register clock
//   rsdi        out  1   row shift-register serial data (row token)
//   oeb         out  1   output enable, active-low (1 = blanked)
//   csdi        out  1   column shift-register serial data, 1 = pixel on
//   cclk        out  1   column shift-register clock
//   le          out  1   column latch enable
//   frame_start out  1   1-cycle pulse when the snapshot for a new frame is taken
// BEHAVIOUR
//   - Reset: oeb=1; rclk=rsdi=csdi=cclk=le=frame_start=0; state=LOAD, row=0. Reset in any
//     state aborts the scan on that edge; the snapshot is not cleared.
//   - All outputs are registered; no combinational input->output path.
//   - Pixel(r,c) = (c==0 & lpad_s[r]) | (c==15 & rpad_s[r]) | (r==y_s & c==x_s); *_s = snapshot.
//   - FSM, per row (total 36 + 2**TIMERWIDTH cycles):
//     LOAD    1 cycle. If row==0: register x,y,lpaddle,rpaddle into snapshot, frame_start=1.
//             Compose the 16-bit row vector from the snapshot.
//     SHIFT   32 cycles, column 15 first, column 0 last. Even cycle: csdi=bit, cclk=0.
//             Odd cycle: cclk=1, csdi held. oeb stays 0: previous row remains visible.
//     BLANK   1 cycle: oeb=1, cclk=0.
//     LATCH   1 cycle: le=1, rsdi=(row==0).
//     RSTEP   1 cycle: le=0, rclk=1, rsdi held. The row token moves to position `row`.
//     DISPLAY 2**TIMERWIDTH cycles: rclk=0, rsdi=0, oeb=0. Dwell counter is TIMERWIDTH bits;
//             leave on wrap to 0. Then row=row+1 (4-bit wrap 15->0) and go to LOAD.
//   - Boundaries:
//     - x,y changing mid-frame: no effect until the next row-0 LOAD.
//     - Ball on a paddle column: OR of both sources, no priority.
//     - Very first frame after reset: oeb=1 until the first DISPLAY; rows shown before the
//       first snapshot use snapshot contents (undefined until written is acceptable; bench
//       ignores them).
// STRUCTURE
//   - Package pong_pkg: DIM=16 localparam; scan_state_t enum (LOAD, SHIFT, BLANK, LATCH,
//     RSTEP, DISPLAY); SHIFT_CYCLES=32.
//   - One sub-module: row_composer (combinational): snapshot + row index -> 16-bit row vector.
//   - FSM, 5-bit shift counter, dwell counter, 4-bit row counter and snapshot registers live
//     in matrix_scan.
// TESTING  (TIMERWIDTH=2 for speed; row period 40 cycles, frame 640)
//   1. Reset held 3 cycles, then released -> oeb=1, le=0, rclk=0; first frame_start pulses
//      in the cycle after release.
//   2. x=5,y=3,lpaddle=16'h0000,rpaddle=16'h0000 -> model of the column chain latched at
//      row 3 = 16'h0020; all other rows latch 16'h0000.
//   3. lpaddle=16'h00F0,rpaddle=16'h0F00,x=0,y=4 -> row 4 = 16'h0001 (overlap ORs);
//      row 9 = 16'h8000.
//   4. Change x from 5 to 6 during row 7 -> rows 7..15 still show col 5; next frame shows col 6.
//   5. Timing check -> each row: 16 cclk rising edges, then exactly 1 le pulse, then
//      1 rclk pulse. rsdi=1 only at row 0. oeb=1 during BLANK..RSTEP only. frame_start
//      every 640 cycles.
//   6. Assert reset in mid-SHIFT of row 9 -> next cycle matches reset values; scan restarts
//      at row 0 with a new snapshot.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong LED-matrix display path.
package pong_pkg;

    localparam int DIM          = 16;
    localparam int SHIFT_CYCLES = 32;

    typedef enum logic [2:0] {
        LOAD,
        SHIFT,
        BLANK,
        LATCH,
        RSTEP,
        DISPLAY
    } scan_state_t;

endpackage

// File: rtl/matrix_scan_row_composer.sv
// Builds the 16-pixel vector for one matrix row from the frame snapshot.
// Bit c of row_vec is column c; paddles sit in columns 0 and 15.
module row_composer
    import pong_pkg::*;
(
    input  logic [3:0]     x_s,
    input  logic [3:0]     y_s,
    input  logic [DIM-1:0] lpad_s,
    input  logic [DIM-1:0] rpad_s,
    input  logic [3:0]     row,
    output logic [DIM-1:0] row_vec
);

    // Paddles and ball are ORed together; a ball on a paddle column just stays lit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        row_vec          = '0;
        row_vec[0]       = lpad_s[row];
        row_vec[DIM-1]   = rpad_s[row];
        if (row == y_s) begin
            row_vec[x_s] = 1'b1;
        end
    end

endmodule

// File: rtl/matrix_scan.sv
// Scans a 16x16 frame (ball + two paddles) row by row onto the LED matrix
// column/row shift-register chains. Inputs are snapshotted at the start of
// each frame so mid-frame updates never tear the image.
module matrix_scan
    import pong_pkg::*;
#(
    parameter int TIMERWIDTH = 10,
    parameter int DIM        = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [3:0]     x,
    input  logic [3:0]     y,
    input  logic [DIM-1:0] lpaddle,
    input  logic [DIM-1:0] rpaddle,
    output logic           rclk,
    output logic           rsdi,
    output logic           oeb,
    output logic           csdi,
    output logic           cclk,
    output logic           le,
    output logic           frame_start
);

    localparam logic [4:0] SHIFT_LAST = 5'(SHIFT_CYCLES - 1);

    scan_state_t           state, state_next;
    logic [4:0]            shift_cnt, shift_cnt_next;
    logic [TIMERWIDTH-1:0] dwell_cnt, dwell_cnt_next;
    logic [3:0]            row, row_next;

    // Frame snapshot
    logic [3:0]            x_s, y_s;
    logic [DIM-1:0]        lpad_s, rpad_s;
    logic                  snap_en;
    logic [DIM-1:0]        row_vec;

    // Next values of the registered outputs
    logic rclk_next, rsdi_next, oeb_next, csdi_next, cclk_next, le_next, frame_start_next;

    row_composer u_row_composer (
        .x_s     (x_s),
        .y_s     (y_s),
        .lpad_s  (lpad_s),
        .rpad_s  (rpad_s),
        .row     (row),
        .row_vec (row_vec)
    );

    // Scan sequencer: next state, counters and output values for the next cycle.
    always_comb begin
        state_next       = state;
        shift_cnt_next   = shift_cnt;
        dwell_cnt_next   = dwell_cnt;
        row_next         = row;
        snap_en          = 1'b0;
        rclk_next        = rclk;
        rsdi_next        = rsdi;
        oeb_next         = oeb;
        csdi_next        = csdi;
        cclk_next        = cclk;
        le_next          = le;
        frame_start_next = 1'b0;

        case (state)
            LOAD: begin
                snap_en          = (row == 4'd0);
                frame_start_next = (row == 4'd0);
                shift_cnt_next   = '0;
                state_next       = SHIFT;
            end
            SHIFT: begin
                // Even cycle presents the bit, odd cycle clocks it; column 15 goes first.
                if (!shift_cnt[0]) begin
                    csdi_next = row_vec[~shift_cnt[4:1]];
                    cclk_next = 1'b0;
                end else begin
                    cclk_next = 1'b1;
                end
                shift_cnt_next = shift_cnt + 5'd1;
                if (shift_cnt == SHIFT_LAST) begin
                    state_next = BLANK;
                end
            end
            BLANK: begin
                oeb_next   = 1'b1;
                cclk_next  = 1'b0;
                state_next = LATCH;
            end
            LATCH: begin
                le_next    = 1'b1;
                rsdi_next  = (row == 4'd0);
                state_next = RSTEP;
            end
            RSTEP: begin
                le_next        = 1'b0;
                rclk_next      = 1'b1;
                dwell_cnt_next = '0;
                state_next     = DISPLAY;
            end
            DISPLAY: begin
                rclk_next      = 1'b0;
                rsdi_next      = 1'b0;
                oeb_next       = 1'b0;
                dwell_cnt_next = dwell_cnt + TIMERWIDTH'(1);
                if (dwell_cnt == '1) begin
                    row_next   = row + 4'd1;
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts the scan on any edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state       <= LOAD;
            shift_cnt   <= '0;
            dwell_cnt   <= '0;
            row         <= '0;
            rclk        <= 1'b0;
            rsdi        <= 1'b0;
            oeb         <= 1'b1;
            csdi        <= 1'b0;
            cclk        <= 1'b0;
            le          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_next;
            shift_cnt   <= shift_cnt_next;
            dwell_cnt   <= dwell_cnt_next;
            row         <= row_next;
            rclk        <= rclk_next;
            rsdi        <= rsdi_next;
            oeb         <= oeb_next;
            csdi        <= csdi_next;
            cclk        <= cclk_next;
            le          <= le_next;
            frame_start <= frame_start_next;
        end
    end

    // Frame snapshot, captured once per frame at the row-0 load.
    always_ff @(posedge clk) begin
        // NOTE: the snapshot is plain data storage and is deliberately not reset;
        // it is always rewritten before the first row that depends on it.
        if (snap_en) begin
            x_s    <= x;
            y_s    <= y;
            lpad_s <= lpaddle;
            rpad_s <= rpaddle;
        end
    end

endmodule

// File: tb/tb_matrix_scan.sv
// Directed bench for matrix_scan: models the column/row shift-register chains
// from the serial pins and compares latched rows and scan timing.
module tb_matrix_scan;

    localparam int TW     = 2;
    localparam int PERIOD = 640;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  x, y;
    logic [15:0] lpaddle, rpaddle;
    logic        rclk, rsdi, oeb, csdi, cclk, le, frame_start;

    matrix_scan #(.TIMERWIDTH(TW), .DIM(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .lpaddle     (lpaddle),
        .rpaddle     (rpaddle),
        .rclk        (rclk),
        .rsdi        (rsdi),
        .oeb         (oeb),
        .csdi        (csdi),
        .cclk        (cclk),
        .le          (le),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Chain model state, updated on the falling clock edge
    logic        mon_en = 1'b0;
    logic        synced = 1'b0;
    logic        prev_cclk = 1'b0, prev_le = 1'b0, prev_rclk = 1'b0;
    logic [15:0] col_sr = '0;
    logic [15:0] latched [16];
    int          cyc = 0, last_fs = 0, fs_count = 0;
    int          row_ptr = 0, rows_seen = 0;
    int          cclk_cnt = 0, le_cnt = 0, oeb_cnt = 0;

    // Edge-detect the output pins and model what the external chains hold.
    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_cclk <= cclk;
        prev_le   <= le;
        prev_rclk <= rclk;
        if (frame_start) fs_count <= fs_count + 1;
        if (!mon_en) begin
            synced <= 1'b0;
        end else if (frame_start) begin
            if (synced) check("frame_period", cyc - last_fs, PERIOD);
            synced    <= 1'b1;
            last_fs   <= cyc;
            row_ptr   <= 0;
            rows_seen <= 0;
            cclk_cnt  <= 0;
            le_cnt    <= 0;
            oeb_cnt   <= 0;
        end else if (synced) begin
            if (oeb) oeb_cnt <= oeb_cnt + 1;
            if (cclk && !prev_cclk) begin
                col_sr   <= {col_sr[14:0], csdi};
                cclk_cnt <= cclk_cnt + 1;
            end
            if (le && !prev_le) begin
                check("cclk_per_row", cclk_cnt, 16);
                if (row_ptr < 16) latched[row_ptr] <= col_sr;
                le_cnt <= le_cnt + 1;
            end
            if (rclk && !prev_rclk) begin
                check("le_per_row", le_cnt, 1);
                check($sformatf("rsdi_row%0d", row_ptr), rsdi, (row_ptr == 0));
                if (rows_seen > 0) check("oeb_blank_len", oeb_cnt + int'(oeb), 3);
                row_ptr   <= row_ptr + 1;
                rows_seen <= rows_seen + 1;
                cclk_cnt  <= 0;
                le_cnt    <= 0;
                oeb_cnt   <= 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fs(input int target);
        int n = 0;
        while (fs_count < target && n < 2000) begin
            tick();
            n++;
        end
        check("frame_start_timeout", (fs_count >= target), 1);
    endtask

    task automatic wait_row(input int r, input int cc);
        int n = 0;
        while (!(row_ptr == r && cclk_cnt >= cc) && n < 1000) begin
            tick();
            n++;
        end
        check("row_wait_timeout", (row_ptr == r), 1);
    endtask

    task automatic check_frame(input string name, input logic [3:0] bx, input logic [3:0] by,
                               input logic [15:0] lp, input logic [15:0] rp);
        logic [15:0] exp;
        for (int r = 0; r < 16; r++) begin
            exp = 16'h0000;
            if (lp[r]) exp = exp | 16'h0001;
            if (rp[r]) exp = exp | 16'h8000;
            if (r == int'(by)) exp = exp | (16'h0001 << bx);
            check($sformatf("%s_row%0d", name, r), latched[r], exp);
        end
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_oeb"}, oeb, 1);
        check({name, "_le"}, le, 0);
        check({name, "_rclk"}, rclk, 0);
        check({name, "_rsdi"}, rsdi, 0);
        check({name, "_cclk"}, cclk, 0);
        check({name, "_csdi"}, csdi, 0);
        check({name, "_frame_start"}, frame_start, 0);
    endtask

    initial begin
        int target;
        reset   = 1'b1;
        x       = 4'd5;
        y       = 4'd3;
        lpaddle = 16'h0000;
        rpaddle = 16'h0000;
        mon_en  = 1'b1;

        // Reset held for 3 edges, then release
        repeat (3) tick();
        check_reset_values("rst");
        reset = 1'b0;
        tick();
        check("fs_after_release", frame_start, 1);
        check("oeb_first_frame", oeb, 1);
        tick();
        check("fs_pulse_width", frame_start, 0);

        // Frame A (ball 5,3) is running; queue paddle-overlap inputs for frame B
        lpaddle = 16'h00F0;
        rpaddle = 16'h0F00;
        x = 4'd0;
        y = 4'd4;
        wait_fs(2);
        check_frame("A", 4'd5, 4'd3, 16'h0000, 16'h0000);
        check("A_row3_hand", latched[3], 16'h0020);

        // Frame B running; queue frame C (ball 5,12, corner paddle rows)
        x = 4'd5;
        y = 4'd12;
        lpaddle = 16'h8001;
        rpaddle = 16'h0000;
        wait_fs(3);
        check_frame("B", 4'd0, 4'd4, 16'h00F0, 16'h0F00);
        check("B_row4_hand", latched[4], 16'h0001);
        check("B_row9_hand", latched[9], 16'h8000);

        // Frame C: move the ball mid-frame; it must not appear until frame D
        wait_row(7, 0);
        x = 4'd6;
        wait_fs(4);
        check_frame("C", 4'd5, 4'd12, 16'h8001, 16'h0000);
        check("C_row12_hand", latched[12], 16'h0020);
        check("C_row0_hand", latched[0], 16'h0001);
        wait_fs(5);
        check_frame("D", 4'd6, 4'd12, 16'h8001, 16'h0000);
        check("D_row12_hand", latched[12], 16'h0040);

        // Reset in the middle of row 9's shift phase
        wait_row(9, 5);
        mon_en = 1'b0;
        reset  = 1'b1;
        tick();
        check_reset_values("midrst");
        x = 4'd9;
        y = 4'd2;
        lpaddle = 16'h0000;
        rpaddle = 16'h0004;
        tick();
        reset  = 1'b0;
        mon_en = 1'b1;
        target = fs_count + 1;
        tick();
        check("fs_after_midrst", frame_start, 1);
        check("fs_count_after_midrst", fs_count, target);
        wait_fs(target + 1);
        check_frame("E", 4'd9, 4'd2, 16'h0000, 16'h0004);
        check("E_row2_hand", latched[2], 16'h8200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
